// File: rtl/ysyx_22040931_bru_bht.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_bru_bht
//
// Branch resolution unit with a bimodal branch history table.
// Resolves the six conditional branches in one registered stage, computes the
// redirect target, flags mispredictions against the fetch-time prediction,
// trains a table of 2-bit saturating counters and serves a same-cycle
// prediction lookup to fetch.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   lk_pc/lk_taken  fetch lookup: prediction = MSB of counter at lk_pc[IDX+1:2]
//   in_*            request (valid/ready handshake), operands, PC, immediate,
//                   prediction used by fetch
//   flush           kills the pending result and blocks a same-cycle accept
//   out_*           registered result (valid/ready handshake)
//   cnt_branch      legal branches accepted
//   cnt_mispred     legal branches accepted that mispredicted
// ----------------------------------------------------------------------------
module ysyx_22040931_bru_bht #(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  lk_pc,
    output logic             lk_taken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_btype,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             out_mispred,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int         IDX       = $clog2(BHT_DEPTH);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]      r_bht [BHT_DEPTH];
    logic            r_out_valid;
    logic            r_out_btype;
    logic            r_out_taken;
    logic [XLEN-1:0] r_out_target;
    logic            r_out_mispred;
    logic [CNT_W-1:0] r_cnt_branch;
    logic [CNT_W-1:0] r_cnt_mispred;

    logic            w_accept;
    logic            w_legal;
    logic            w_eq;
    logic            w_lt;
    logic [XLEN:0]   w_diff;
    logic            w_ltu;
    logic            w_cond;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_mispred;
    logic            w_upd;
    logic [IDX-1:0]  w_tr_idx;
    logic [IDX-1:0]  w_lk_idx;

    // Ready is held low during reset so nothing is captured in that cycle.
    assign in_ready = rst_n && !flush && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_legal = (in_opcode == OP_BRANCH) && (in_funct3[2:1] != 2'b01);

    assign w_eq   = (in_rs1 == in_rs2);
    assign w_lt   = ($signed(in_rs1) < $signed(in_rs2));
    // Zero-extended subtraction: the top bit is the unsigned borrow.
    assign w_diff = {1'b0, in_rs1} - {1'b0, in_rs2};
    assign w_ltu  = w_diff[XLEN];

    // funct3[2:1] selects the relation, funct3[0] inverts it.
    always_comb begin
        w_cond = 1'b0;
        case (in_funct3[2:1])
            2'b00:   w_cond = w_eq;
            2'b10:   w_cond = w_lt;
            2'b11:   w_cond = w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken   = w_legal && (w_cond ^ in_funct3[0]);
    assign w_target  = w_taken ? (in_pc + in_imm) : (in_pc + XLEN'(4));
    assign w_mispred = w_legal && (w_taken != in_pred);
    assign w_upd     = w_accept && w_legal;

    assign w_tr_idx = in_pc[IDX+1:2];
    assign w_lk_idx = lk_pc[IDX+1:2];

    // Read-before-write: the lookup sees the registered value this cycle.
    assign lk_taken = r_bht[w_lk_idx][1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_upd) begin
            if (w_taken && (r_bht[w_tr_idx] != 2'b11)) begin
                r_bht[w_tr_idx] <= r_bht[w_tr_idx] + 2'b01;
            end else if (!w_taken && (r_bht[w_tr_idx] != 2'b00)) begin
                r_bht[w_tr_idx] <= r_bht[w_tr_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_btype   <= 1'b0;
            r_out_taken   <= 1'b0;
            r_out_target  <= '0;
            r_out_mispred <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Payload only moves on accept, so it holds while stalled.
            if (w_accept) begin
                r_out_btype   <= w_legal;
                r_out_taken   <= w_taken;
                r_out_target  <= w_target;
                r_out_mispred <= w_mispred;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_branch  <= '0;
            r_cnt_mispred <= '0;
        end else if (w_upd) begin
            r_cnt_branch <= r_cnt_branch + CNT_W'(1);
            if (w_mispred) begin
                r_cnt_mispred <= r_cnt_mispred + CNT_W'(1);
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_btype   = r_out_btype;
    assign out_taken   = r_out_taken;
    assign out_target  = r_out_target;
    assign out_mispred = r_out_mispred;
    assign cnt_branch  = r_cnt_branch;
    assign cnt_mispred = r_cnt_mispred;

endmodule

// File: tb/tb_ysyx_22040931_bru_bht.sv
module tb_ysyx_22040931_bru_bht;

    localparam int XLEN  = 64;
    localparam int DEPTH = 64;
    localparam int CNT_W = 32;
    localparam logic [6:0] OPB = 7'b1100011;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [XLEN-1:0]  lk_pc = '0;
    logic             lk_taken;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_opcode = '0;
    logic [2:0]       in_funct3 = '0;
    logic [XLEN-1:0]  in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
    logic             in_pred = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_btype, out_taken, out_mispred;
    logic [XLEN-1:0]  out_target;
    logic [CNT_W-1:0] cnt_branch, cnt_mispred;

    ysyx_22040931_bru_bht #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_taken(lk_taken),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
        .in_imm(in_imm), .in_pred(in_pred), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_btype(out_btype),
        .out_taken(out_taken), .out_target(out_target), .out_mispred(out_mispred),
        .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            btype;
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mispred;
    } exp_t;

    exp_t        q[$];
    int          bht[DEPTH];
    logic [31:0] m_cb = 0, m_cm = 0;
    int          errors = 0, checks = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    // Reference behaviour written directly from the branch rules.
    function automatic exp_t resolve(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [XLEN-1:0] a, b, pc, imm, input logic pred);
        exp_t e;
        logic t;
        e.btype = (op == OPB) && (f3 != 3'd2) && (f3 != 3'd3);
        t = 1'b0;
        if (e.btype) begin
            case (f3)
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd4: t = ($signed(a) < $signed(b));
                3'd5: t = ($signed(a) >= $signed(b));
                3'd6: t = (a < b);
                default: t = (a >= b);
            endcase
        end
        e.taken   = t;
        e.target  = t ? pc + imm : pc + 64'd4;
        e.mispred = e.btype && (t != pred);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) bht[i] = 1;
        m_cb = 0;
        m_cm = 0;
        q.delete();
    endtask

    // One clock cycle: drive at negedge, check lookup/ready/stats, model the edge.
    task automatic cyc(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, b, pc, imm, input logic pred,
                       input logic fl, input logic ordy, input logic [XLEN-1:0] lpc,
                       input logic rst);
        logic exp_rdy, acc;
        exp_t e;
        @(negedge clk);
        rst_n = rst; in_valid = v; in_opcode = op; in_funct3 = f3;
        in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm; in_pred = pred;
        flush = fl; out_ready = ordy; lk_pc = lpc;
        #1;
        chk("lk_taken", XLEN'(lk_taken), XLEN'(bht[idx_of(lpc)] >= 2));
        exp_rdy = rst && !fl && (q.size() == 0 || ordy);
        chk("in_ready", XLEN'(in_ready), XLEN'(exp_rdy));
        chk("cnt_branch", XLEN'(cnt_branch), XLEN'(m_cb));
        chk("cnt_mispred", XLEN'(cnt_mispred), XLEN'(m_cm));
        acc = v && exp_rdy;
        e = resolve(op, f3, a, b, pc, imm, pred);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (acc) begin
            if (e.btype) begin
                bht[idx_of(pc)] = e.taken ? ((bht[idx_of(pc)] < 3) ? bht[idx_of(pc)] + 1 : 3)
                                          : ((bht[idx_of(pc)] > 0) ? bht[idx_of(pc)] - 1 : 0);
                m_cb = m_cb + 1;
                if (e.mispred) m_cm = m_cm + 1;
            end
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 7'd0, 3'd0, '0, '0, 64'h8000_0000, '0, 1'b0, 1'b0, ordy, 64'h8000_0000, 1'b1);
    endtask

    task automatic br(input logic [2:0] f3, input logic [XLEN-1:0] a, b, pc, imm, input logic pred);
        cyc(1'b1, OPB, f3, a, b, pc, imm, pred, 1'b0, 1'b1, pc, 1'b1);
    endtask

    task automatic reset_and_check();
        cyc(1'b1, OPB, 3'd0, 64'd5, 64'd5, 64'h8000_0000, 64'd8, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 1'b0);
        #1;
        chk("rst out_valid", XLEN'(out_valid), '0);
        chk("rst out_target", out_target, '0);
        chk("rst out_taken", XLEN'(out_taken), '0);
        chk("rst out_btype", XLEN'(out_btype), '0);
        chk("rst out_mispred", XLEN'(out_mispred), '0);
        chk("rst lk_taken", XLEN'(lk_taken), '0);
    endtask

    // Monitor: compares the head of the scoreboard with the presented result.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("out_valid", XLEN'(out_valid), XLEN'(q.size() != 0));
                if (q.size() != 0) begin
                    chk("out_btype", XLEN'(out_btype), XLEN'(q[0].btype));
                    chk("out_taken", XLEN'(out_taken), XLEN'(q[0].taken));
                    chk("out_target", out_target, q[0].target);
                    chk("out_mispred", XLEN'(out_mispred), XLEN'(q[0].mispred));
                    if (out_ready || flush) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [XLEN-1:0] a, b, pc, imm;
        model_reset();
        reset_and_check();
        idle(1'b1);

        // Unsigned vs signed on the same operands.
        br(3'd6, 64'd1, '1, 64'h8000_0010, -64'sd16, 1'b0);
        br(3'd4, 64'd1, '1, 64'h8000_0010, -64'sd16, 1'b0);
        idle(1'b1);

        // Train one entry up to saturation and back down.
        for (int i = 0; i < 4; i++) br(3'd0, 64'd7, 64'd7, 64'h8000_0020, 64'd64, 1'b1);
        for (int i = 0; i < 2; i++) br(3'd0, 64'd7, 64'd8, 64'h8000_0020, 64'd64, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Stall for three cycles, then release with a new request.
        br(3'd1, 64'd1, 64'd2, 64'h8000_0040, 64'd32, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, OPB, 3'd5, 64'd3, 64'd2, 64'h8000_0044, 64'd12, 1'b1, 1'b0, 1'b0, 64'h8000_0044, 1'b1);
        cyc(1'b1, OPB, 3'd5, 64'd3, 64'd2, 64'h8000_0044, 64'd12, 1'b1, 1'b0, 1'b1, 64'h8000_0044, 1'b1);
        idle(1'b1);

        // Illegal funct3 and foreign opcode.
        br(3'd2, 64'd1, 64'd1, 64'h8000_0050, 64'd100, 1'b1);
        cyc(1'b1, 7'b0110011, 3'd0, 64'd1, 64'd1, 64'h8000_0054, 64'd100, 1'b1, 1'b0, 1'b1, 64'h8000_0054, 1'b1);
        idle(1'b1);

        // Flush with pending stalled result and a new request.
        br(3'd0, 64'd9, 64'd9, 64'h8000_0060, 64'd4, 1'b0);
        cyc(1'b1, OPB, 3'd0, 64'd9, 64'd9, 64'h8000_0060, 64'd4, 1'b0, 1'b1, 1'b0, 64'h8000_0060, 1'b1);
        idle(1'b1);

        // PC wrap-around.
        br(3'd7, 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'd16, 1'b0);
        br(3'd6, 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd16, 1'b0);
        idle(1'b1);

        // Reset while a result is valid.
        br(3'd0, 64'd1, 64'd1, 64'h8000_0070, 64'd8, 1'b0);
        reset_and_check();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {$urandom, $urandom};
                2: b = a ^ 64'h8000_0000_0000_0000;
                default: b = a + 64'($urandom_range(0, 2)) - 64'd1;
            endcase
            pc  = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 63) * 4)
                                                : 64'h8000_0000 + 64'($urandom_range(0, 127) * 4);
            imm = ($urandom_range(0, 1) != 0) ? 64'($signed($urandom_range(0, 8191)) - 4096)
                                              : {$urandom, $urandom};
            if ($urandom_range(0, 599) == 0) begin
                reset_and_check();
            end else begin
                cyc($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 7) == 0) ? 7'($urandom) : OPB,
                    3'($urandom), a, b, pc, imm, 1'($urandom),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 1) != 0) ? pc : 64'h8000_0000 + 64'($urandom_range(0, 127) * 4),
                    1'b1);
            end
        end
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
